// File: rtl/xrnic_chk_pkg.sv
// Shared types and defaults for the xrnic result checker: FSM state encoding,
// default sizing and the conventional channel assignment of the ERNIC counters.
package xrnic_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CMP   = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    localparam int NUM_CH_DEF     = 4;
    localparam int CNT_W_DEF      = 16;
    localparam int TMO_W_DEF      = 32;
    localparam int TMO_CYCLES_DEF = 50000;

    localparam int CH_SEND      = 0;
    localparam int CH_RD_RESP   = 1;
    localparam int CH_RD_WR_WQE = 2;
    localparam int CH_ACK       = 3;

endpackage

// File: rtl/xrnic_result_checker_timer.sv
// xrnic_chk_timer: loadable down-counter that saturates at zero; expired is
// high whenever the count is zero.
module xrnic_chk_timer #(
    parameter int TMO_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMO_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/xrnic_result_checker.sv
// End-of-test counter checker: arms on start, compares enabled channels one per
// cycle after a final_done rising edge. XRNIC_RESULT_CHECKER_SNAPSHOT_EN freezes counters at the edge.
module xrnic_result_checker
    import xrnic_chk_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TMO_W      = TMO_W_DEF,
    parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic                    aclk,
    input  logic                    cmac_rst,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] exp_cnt,
    input  logic [NUM_CH*CNT_W-1:0] act_cnt,
    input  logic                    final_done,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic [NUM_CH-1:0]       fail_mask,
    output logic                    cfg_err,
    output logic                    timeout
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = (TMO_CYCLES == 0) ? '0 : TMO_W'(TMO_CYCLES - 1);

    chk_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_CH-1:0]       ch_en_q, ch_en_d;
    logic [NUM_CH*CNT_W-1:0] exp_q, exp_d;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic                    pass_q, pass_d;
    logic                    fail_q, fail_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    timeout_q, timeout_d;
    logic                    prev_fd_q, prev_fd_d;
    logic                    edge_q, edge_d;
    logic                    tmr_load, tmr_en, tmr_expired, tmo_hit;
    logic [CNT_W-1:0]        cur_act, cur_exp;

`ifdef XRNIC_RESULT_CHECKER_SNAPSHOT_EN
    logic [NUM_CH*CNT_W-1:0] snap_q, snap_d;
    assign cur_act = snap_q[idx_q*CNT_W +: CNT_W];
`else
    assign cur_act = act_cnt[idx_q*CNT_W +: CNT_W];
`endif
    assign cur_exp = exp_q[idx_q*CNT_W +: CNT_W];
    assign tmo_hit = (TMO_CYCLES != 0) && tmr_expired;

    xrnic_chk_timer #(.TMO_W(TMO_W)) u_timer (
        .clk      (aclk),
        .rst      (cmac_rst),
        .load     (tmr_load),
        .load_val (TMO_LOAD),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ch_en_d   = ch_en_q;
        exp_d     = exp_q;
        mask_d    = mask_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        cfg_err_d = cfg_err_q;
        timeout_d = timeout_q;
        prev_fd_d = final_done;
        edge_d    = final_done & ~prev_fd_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
`ifdef XRNIC_RESULT_CHECKER_SNAPSHOT_EN
        snap_d    = snap_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ch_en_d   = ch_en;
                    exp_d     = exp_cnt;
                    mask_d    = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    cfg_err_d = 1'b0;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    tmr_load  = 1'b1;
                    // A level already high at arm time must not look like an edge.
                    edge_d    = 1'b0;
                    if (ch_en == '0) begin
                        state_d   = ST_DONE;
                        cfg_err_d = 1'b1;
                        fail_d    = 1'b1;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                tmr_en = 1'b1;
                if (edge_q) begin
                    state_d = ST_CMP;
                    idx_d   = '0;
`ifdef XRNIC_RESULT_CHECKER_SNAPSHOT_EN
                    snap_d  = act_cnt;
`endif
                end else if (tmo_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                end
            end
            ST_CMP: begin
                if (ch_en_q[idx_q] && (cur_act != cur_exp)) begin
                    mask_d[idx_q] = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    pass_d  = (mask_d == '0);
                    fail_d  = (mask_d != '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge cmac_rst) begin
        if (cmac_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ch_en_q   <= '0;
            exp_q     <= '0;
            mask_q    <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            timeout_q <= 1'b0;
            prev_fd_q <= 1'b0;
            edge_q    <= 1'b0;
`ifdef XRNIC_RESULT_CHECKER_SNAPSHOT_EN
            snap_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ch_en_q   <= ch_en_d;
            exp_q     <= exp_d;
            mask_q    <= mask_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            cfg_err_q <= cfg_err_d;
            timeout_q <= timeout_d;
            prev_fd_q <= prev_fd_d;
            edge_q    <= edge_d;
`ifdef XRNIC_RESULT_CHECKER_SNAPSHOT_EN
            snap_q    <= snap_d;
`endif
        end
    end

    assign busy      = (state_q == ST_ARMED) || (state_q == ST_CMP);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_mask = mask_q;
    assign cfg_err   = cfg_err_q;
    assign timeout   = timeout_q;

endmodule
